// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree feeding a saturating multi-beat window accumulator.
// Reports land one register after the accumulator, so each report reads a settled acc value.
module pipelined_adder_tree #(
    parameter int N_STAGE    = 5,
    parameter int IN_BITS    = 2,
    parameter int PIPE_EVERY = 1,
    parameter int ACC_BITS   = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic                               in_first,
    input  logic                               in_last,
    input  logic [(2**N_STAGE)*IN_BITS-1:0]    x,
    output logic                               out_valid,
    output logic signed [ACC_BITS-1:0]         sum_out,
    output logic                               out_sat
);
    localparam int NIN = 2**N_STAGE;
    localparam int TW  = IN_BITS + N_STAGE;
    localparam int AW  = ACC_BITS + 1;

    // Every node is carried at the final width; bits above IN_BITS+s are pure sign extension.
    for (genvar s = 0; s <= N_STAGE; s++) begin : g_stg
        localparam int CNT = NIN >> s;
        logic signed [TW-1:0] node [CNT];
        logic                 v, f, l;

        if (s == 0) begin : g_in
            always_comb begin
                for (int j = 0; j < CNT; j++) begin
                    node[j] = {{N_STAGE{x[j*IN_BITS+IN_BITS-1]}}, x[j*IN_BITS +: IN_BITS]};
                end
            end
            assign v = in_valid;
            assign f = in_first;
            assign l = in_last;
        end else begin : g_add
            logic signed [TW-1:0] sum [CNT];

            always_comb begin
                for (int j = 0; j < CNT; j++) begin
                    sum[j] = g_stg[s-1].node[2*j] + g_stg[s-1].node[2*j+1];
                end
            end

            if ((s % PIPE_EVERY == 0) || (s == N_STAGE)) begin : g_reg
                logic signed [TW-1:0] node_q [CNT];
                logic                 v_q, f_q, l_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_q <= 1'b0;
                        f_q <= 1'b0;
                        l_q <= 1'b0;
                    end else begin
                        v_q <= g_stg[s-1].v;
                        f_q <= g_stg[s-1].f;
                        l_q <= g_stg[s-1].l;
                    end
                end

                always_ff @(posedge clk) begin
                    node_q <= sum;
                end

                assign node = node_q;
                assign v    = v_q;
                assign f    = f_q;
                assign l    = l_q;
            end else begin : g_comb
                assign node = sum;
                assign v    = g_stg[s-1].v;
                assign f    = g_stg[s-1].f;
                assign l    = g_stg[s-1].l;
            end
        end
    end

    logic signed [TW-1:0]       tree;
    logic                       tv, tf, tl;
    logic signed [AW-1:0]       t, base, raw;
    logic                       restart, ovf;
    logic signed [ACC_BITS-1:0] acc_d, acc_q;
    logic                       sat_d, sat_q;
    logic                       open_q, pend_q;
    logic                       out_valid_q, out_sat_q;
    logic signed [ACC_BITS-1:0] sum_out_q;

    assign tree = g_stg[N_STAGE].node[0];
    assign tv   = g_stg[N_STAGE].v;
    assign tf   = g_stg[N_STAGE].f;
    assign tl   = g_stg[N_STAGE].l;

    // One guard bit above the accumulator: acc + t always fits, so overflow is a top-two-bit disagreement.
    always_comb begin
        restart = tf | ~open_q;
        t       = {{(AW-TW){tree[TW-1]}}, tree};
        base    = restart ? '0 : {acc_q[ACC_BITS-1], acc_q};
        raw     = base + t;
        ovf     = raw[AW-1] ^ raw[AW-2];
        if (ovf) begin
            acc_d = raw[AW-1] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
        end else begin
            acc_d = raw[ACC_BITS-1:0];
        end
        sat_d = ovf | (~restart & sat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            open_q      <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sum_out_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            pend_q      <= tv & tl;
            out_valid_q <= pend_q;
            if (tv) begin
                acc_q  <= acc_d;
                sat_q  <= sat_d;
                open_q <= ~tl;
            end
            if (pend_q) begin
                sum_out_q <= acc_q;
                out_sat_q <= sat_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum_out   = sum_out_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Drives six adder-tree instances (PIPE_EVERY 1..5 at ACC_BITS=12, plus PIPE_EVERY=2 at ACC_BITS=8)
// from one stimulus stream and checks each against a window-sum reference model.
module tb_pipelined_adder_tree;
    localparam int NDUT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inValid = 1'b0;
    logic        inFirst = 1'b0;
    logic        inLast = 1'b0;
    logic [63:0] x = '0;

    logic ovA [NDUT];
    logic osA [NDUT];
    int   soA [NDUT];

    int edgeCnt = 0;
    int total = 0;
    int bad = 0;

    int mAcc [NDUT];
    bit mSat [NDUT];
    bit mOpen [NDUT];
    int lastSum [NDUT];
    int lastSat [NDUT];
    int dueQ [NDUT][$];
    int sumQ [NDUT][$];
    int satQ [NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt++;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int PEV = (g < 5) ? g + 1 : 2;
        localparam int ABV = (g < 5) ? 12 : 8;
        logic                  ov, os;
        logic signed [ABV-1:0] so;

        pipelined_adder_tree #(
            .N_STAGE(5), .IN_BITS(2), .PIPE_EVERY(PEV), .ACC_BITS(ABV)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_first(inFirst),
            .in_last(inLast), .x(x), .out_valid(ov), .sum_out(so), .out_sat(os)
        );

        assign ovA[g] = ov;
        assign osA[g] = os;
        assign soA[g] = int'(so);
    end

    function automatic int accBitsOf(int i);
        return (i < 5) ? 12 : 8;
    endfunction

    // Edges from sampling to out_valid: ceil(5/PIPE_EVERY) tree registers, acc register, report register.
    function automatic int latOf(int i);
        int pe;
        pe = (i < 5) ? i + 1 : 2;
        return (5 + pe - 1) / pe + 1;
    endfunction

    function automatic logic [63:0] makeN(int n, int val);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j*2 +: 2] = 2'(val);
        return r;
    endfunction

    task automatic checkOutput(string tag, int obs, int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edgeCnt);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NDUT; i++) begin
            mAcc[i] = 0;
            mSat[i] = 1'b0;
            mOpen[i] = 1'b0;
            lastSum[i] = 0;
            lastSat[i] = 0;
            dueQ[i].delete();
            sumQ[i].delete();
            satQ[i].delete();
        end
    endtask

    task automatic modelBeat(logic [63:0] xv, bit f, bit l, int sampleEdge);
        int t;
        logic signed [1:0] e;
        t = 0;
        for (int j = 0; j < 32; j++) begin
            e = xv[j*2 +: 2];
            t += int'(e);
        end
        for (int i = 0; i < NDUT; i++) begin
            int hi, lo, raw;
            bit fresh;
            hi = (1 << (accBitsOf(i) - 1)) - 1;
            lo = -(1 << (accBitsOf(i) - 1));
            fresh = f || !mOpen[i];
            raw = fresh ? t : mAcc[i] + t;
            mSat[i] = (fresh ? 1'b0 : mSat[i]) | (raw > hi || raw < lo);
            mAcc[i] = (raw > hi) ? hi : (raw < lo) ? lo : raw;
            mOpen[i] = !l;
            if (l) begin
                dueQ[i].push_back(sampleEdge + latOf(i));
                sumQ[i].push_back(mAcc[i]);
                satQ[i].push_back(int'(mSat[i]));
            end
        end
    endtask

    task automatic checkCycle();
        for (int i = 0; i < NDUT; i++) begin
            int due;
            due = 0;
            if (dueQ[i].size() != 0 && dueQ[i][0] == edgeCnt) begin
                due = 1;
                void'(dueQ[i].pop_front());
                lastSum[i] = sumQ[i].pop_front();
                lastSat[i] = satQ[i].pop_front();
            end
            checkOutput($sformatf("u%0d.out_valid", i), int'(ovA[i]), due);
            checkOutput($sformatf("u%0d.sum_out", i), soA[i], lastSum[i]);
            checkOutput($sformatf("u%0d.out_sat", i), int'(osA[i]), lastSat[i]);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge samples them.
    task automatic applyStimulus(bit v, bit f, bit l, logic [63:0] xv);
        inValid = v;
        inFirst = f;
        inLast = l;
        x = xv;
        if (v) modelBeat(xv, f, l, edgeCnt + 1);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic applyReset(int cycles);
        inValid = 1'b0;
        inFirst = 1'b0;
        inLast = 1'b0;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkCycle();
        repeat (cycles) begin
            @(negedge clk);
            checkCycle();
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
    endtask

    initial begin
        clearModel();
        #2;
        applyReset(2);

        $display("[TB] single-beat windows");
        applyStimulus(1, 1, 1, makeN(32, 1));
        idle(8);
        applyStimulus(1, 1, 1, makeN(32, -2));
        idle(8);

        $display("[TB] three-beat window with gaps");
        applyStimulus(1, 1, 0, makeN(32, 1));
        idle(1);
        applyStimulus(1, 0, 0, makeN(32, -1));
        applyStimulus(1, 0, 1, makeN(16, 1));
        idle(8);

        $display("[TB] saturation then clean window");
        applyStimulus(1, 1, 0, makeN(32, 1));
        applyStimulus(1, 0, 0, makeN(32, 1));
        applyStimulus(1, 0, 0, makeN(32, 1));
        applyStimulus(1, 0, 1, makeN(32, 1));
        applyStimulus(1, 1, 1, makeN(32, 1));
        idle(8);
        applyStimulus(1, 1, 0, makeN(32, -2));
        applyStimulus(1, 0, 0, makeN(32, -2));
        applyStimulus(1, 0, 0, makeN(32, -2));
        applyStimulus(1, 0, 1, makeN(32, -2));
        idle(8);

        $display("[TB] back-to-back windows");
        applyStimulus(1, 1, 1, makeN(0, 1));
        applyStimulus(1, 1, 1, makeN(5, 1));
        applyStimulus(1, 1, 1, makeN(7, -1));
        applyStimulus(1, 1, 1, makeN(31, 1));
        idle(8);

        $display("[TB] restart discards partial window");
        applyStimulus(1, 1, 0, makeN(32, 1));
        applyStimulus(1, 1, 1, makeN(3, 1));
        applyStimulus(1, 0, 0, makeN(10, 1));
        applyStimulus(1, 0, 1, makeN(2, -1));
        idle(8);

        $display("[TB] reset mid-window");
        applyStimulus(1, 1, 1, makeN(9, 1));
        applyStimulus(1, 1, 0, makeN(32, 1));
        applyStimulus(1, 0, 0, makeN(32, 1));
        applyReset(2);
        idle(8);
        applyStimulus(1, 1, 1, makeN(32, 1));
        idle(8);

        $display("[TB] random beats");
        for (int n = 0; n < 400; n++) begin
            logic [63:0] xv;
            case ($urandom_range(0, 5))
                0: xv = makeN(32, 1);
                1: xv = makeN(32, -2);
                default: xv = {$urandom, $urandom};
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 3) == 0, xv);
        end
        idle(10);

        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("u%0d.pending_reports", i), dueQ[i].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder_tree.md
# pipelined_adder_tree

Pipelined, accumulating successor to the combinational signed adder tree in the neuron datapath. Each cycle it reduces 2**N_STAGE signed IN_BITS-bit weighted inputs through a binary adder tree. Pipeline registers are inserted every PIPE_EVERY stages. Results from a multi-beat window (first…last) are summed into a saturating accumulator, so a neuron with more synapses than one tree width can be integrated over several cycles. It sits between the weight/spike gating logic and the membrane-potential update.

## Interface

**Parameters**
- N_STAGE, 5: number of adder stages. Inputs = 2**N_STAGE. Minimum 1.
- IN_BITS, 2: width of each signed input element. Minimum 2.
- PIPE_EVERY, 1: register after every PIPE_EVERY tree stages. The final stage is always registered. Range 1..N_STAGE.
- ACC_BITS, 12: signed accumulator and output width. Must be ≥ IN_BITS+N_STAGE.

**Ports**
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: x carries a beat this cycle.
- in_first, input, 1: beat opens a window. Qualified by in_valid.
- in_last, input, 1: beat closes a window. Qualified by in_valid.
- x, input, (2**N_STAGE)*IN_BITS: packed signed elements. Element j is x[j*IN_BITS +: IN_BITS].
- out_valid, output, 1: one-cycle pulse; sum_out and out_sat are valid.
- sum_out, output, ACC_BITS, signed: saturated window sum.
- out_sat, output, 1: saturation occurred at least once in the reported window.

## Operation

- **Tree.** Stage s (1-based) adds adjacent pairs from stage s-1 with sign extension. Stage s output width is IN_BITS+s, so no stage can overflow. The final width is IN_BITS+N_STAGE.
- **Pipeline registers.** A register sits after stage s when s mod PIPE_EVERY == 0 or s == N_STAGE. Pipeline depth is L = ceil(N_STAGE/PIPE_EVERY).
- **Sideband.** in_valid, in_first and in_last travel alongside the data through every pipeline register. Data registers may hold stale values when valid is 0.
- **No backpressure.** A new beat may enter every cycle.
- **Accumulator.** Let t be the tree result sign-extended to ACC_BITS+1 bits. Each cycle the tree-output valid is high:
  - first, or no window open: acc ← sat(t) and sat_flag ← (t out of range).
  - otherwise: acc ← sat(acc + t) and sat_flag ← sat_flag | overflow.
  - A window is open from a first beat until its last beat. A valid beat while no window is open is treated as first.
- **Saturation.** sat clamps to the range [-2**(ACC_BITS-1), 2**(ACC_BITS-1)-1].
- **Output.** On a tree-output beat with last=1, the next-cycle registers load sum_out ← the new acc value and out_sat ← the new sat_flag. out_valid pulses for one cycle and the window closes.
  - first and last on the same beat gives a single-beat window.
  - Back-to-back windows need no idle cycle.
- **Hold.** sum_out and out_sat hold their value until the next report. out_valid is 0 in all other cycles.
- **Reset.** Asserting rst_n=0 at any time clears all pipeline valid bits, acc, sat_flag, the window-open state, sum_out, out_sat and out_valid. In-flight beats are discarded; no stale out_valid appears after reset release.

## Timing

- **Reset values:** out_valid=0, sum_out=0, out_sat=0.
- **Latency:** a beat sampled at edge k with in_last=1 produces out_valid=1 during the cycle after edge k+L+1. That is L pipeline registers plus one accumulator/output register.
- **Throughput:** one beat per cycle. One report per window, at most one report per cycle.
- **Idle beats:** beats with in_valid=0 inside a window do not disturb acc. Gaps within a window are legal.
- **Window boundaries:** an in_first while a window is open discards the open partial sum and restarts. No report is issued for the discarded window.
- **Combinational path:** no combinational path from inputs to outputs.

## Test plan

1. **Single-beat positive sum.** Defaults with PIPE_EVERY=2, so L=3. All 32 elements = +1, first=last=1. Required: out_valid exactly 4 edges later, sum_out=32, out_sat=0.
2. **Single-beat negative sum.** All elements = -2, single-beat window. Required: sum_out=-64, out_sat=0.
3. **Three-beat window with gaps.**
   - Beat 1: all +1. Idle cycle. Beat 2: all -1. Beat 3 (last): 16×(+1) and 16×0.
   - Required: exactly one out_valid, sum_out=16, no report for beats 1–2.
4. **Saturation.** ACC_BITS=8, four-beat window of all +1 (true sum 128). Required: sum_out=127, out_sat=1. A following single-beat window of all +1 must report 32 with out_sat=0.
5. **Back-to-back windows and sweep.** Single-beat windows every cycle with sums 0, 5, -7, 31. Required: out_valid high for 4 consecutive cycles with values in that order. Repeat for PIPE_EVERY=1..5, checking latency = ceil(5/PIPE_EVERY)+1.
6. **Reset mid-window.** Assert rst_n=0 with two beats in flight and a window open, then release. Required: all outputs 0 immediately. No out_valid after release until a new complete window. The next single-beat window of all +1 reports 32.
